// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM state encodings, the
// out-of-range read pattern and the wait-counter width helper.
package dmem_responder_pkg;

  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_RESP = 2'd2;

  localparam logic [31:0] DMEM_BAD_DATA = 32'hDEAD_BEEF;

  // Bits needed to hold 0..maxVal; never less than one.
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal > 0) ? $clog2(maxVal + 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with four byte enables and a registered read port.
// Only the read register is cleared by reset; the array contents are not.
module dmem_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  re,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdataQ;

  // Byte-lane write: each strobe bit writes its own 8-bit lane.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read; the output register holds its value until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdataQ <= '0;
    end else if (re) begin
      rdataQ <= mem[addr];
    end
  end

  assign rdata = rdataQ;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU data port. Accepts one access at a time,
// inserts WAIT_CYCLES (+UNCACHED_EXTRA when no_dcache) wait states, then
// completes with a one-cycle data_ok pulse while stalling the pipeline.
// Optional feature: define DMEM_RANGE_CHECK_EN to flag accesses whose upper
// address bits are non-zero (write suppressed, DEAD_BEEF returned, err pulsed).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned WAIT_CYCLES    = 2,
  parameter int unsigned UNCACHED_EXTRA = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic [3:0]  memwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] wdata,
  input  logic        no_dcache,
  output logic [31:0] rdata,
  output logic        data_ok,
  output logic        stall,
  output logic        err
);

  localparam int unsigned CntMax = WAIT_CYCLES + UNCACHED_EXTRA;
  localparam int unsigned CntW   = cntWidth(CntMax);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [1:0]            stateQ, stateD;
  logic [CntW-1:0]       cntQ, cntD;
  logic [CntW-1:0]       loadCnt;
  logic [ADDR_WIDTH-1:0] idxQ;
  logic [3:0]            weQ;
  logic [31:0]           wdataQ;
  logic                  badQ;
  logic                  respBadQ;
  logic                  accept;
  logic                  enterResp;
  logic                  acceptBad;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic [3:0]            ramWe;
  logic [31:0]           ramRdata;
  logic                  unusedAddr;

  assign accept  = (stateQ == DMEM_IDLE) && memen;
  assign loadCnt = no_dcache ? CntW'(CntMax) : CntW'(WAIT_CYCLES);

`ifdef DMEM_RANGE_CHECK_EN
  assign acceptBad = (paddr[31:ADDR_WIDTH+2] != '0);
`else
  assign acceptBad = 1'b0;
`endif

  // Byte-offset bits are never used; upper bits only matter with the range check.
  assign unusedAddr = ^{paddr[1:0], paddr[31:ADDR_WIDTH+2]};

  // Next-state and wait-counter logic for IDLE -> WAIT -> RESP -> IDLE.
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    enterResp = 1'b0;
    case (stateQ)
      DMEM_IDLE: begin
        if (memen) begin
          cntD = loadCnt;
          if (loadCnt != '0) begin
            stateD = DMEM_WAIT;
          end else begin
            stateD    = DMEM_RESP;
            enterResp = 1'b1;
          end
        end
      end
      DMEM_WAIT: begin
        if (cntQ == CntOne) begin
          stateD    = DMEM_RESP;
          enterResp = 1'b1;
          cntD      = '0;
        end else begin
          cntD = cntQ - CntOne;
        end
      end
      DMEM_RESP: stateD = DMEM_IDLE;
      default:   stateD = DMEM_IDLE;
    endcase
  end

  // State, counter and the response-side out-of-range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= DMEM_IDLE;
      cntQ     <= '0;
      respBadQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      // Captured with the RAM read so rdata stays stable until the next data_ok.
      if (enterResp) begin
        respBadQ <= (stateQ == DMEM_IDLE) ? acceptBad : badQ;
      end
    end
  end

  // Request latches: captured once at acceptance, ignored inputs afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      idxQ   <= paddr[ADDR_WIDTH+1:2];
      weQ    <= memwrite;
      wdataQ <= wdata;
      badQ   <= acceptBad;
    end
  end

  // In IDLE the RAM sees the live address so a zero-wait access can read at once.
  assign ramAddr = (stateQ == DMEM_IDLE) ? paddr[ADDR_WIDTH+1:2] : idxQ;
  // Write lands on the edge ending RESP, after the pre-write word was read.
  assign ramWe   = ((stateQ == DMEM_RESP) && !rst && !badQ) ? weQ : 4'b0000;

  dmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uRam (
    .clk  (clk),
    .rst  (rst),
    .addr (ramAddr),
    .re   (enterResp),
    .we   (ramWe),
    .wdata(wdataQ),
    .rdata(ramRdata)
  );

  assign data_ok = (stateQ == DMEM_RESP);
  assign stall   = ((stateQ != DMEM_IDLE) && !data_ok) || ((stateQ == DMEM_IDLE) && memen);
  assign rdata   = respBadQ ? DMEM_BAD_DATA : ramRdata;

`ifdef DMEM_RANGE_CHECK_EN
  assign err = data_ok && respBadQ;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (default timing, and zero-wait with
// one uncached extra cycle) checked against a word-array reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        memen    [2];
  logic [3:0]  memwrite [2];
  logic [31:0] paddr    [2];
  logic [31:0] wdata    [2];
  logic        noDcache [2];
  logic [31:0] rdata    [2];
  logic        dataOk   [2];
  logic        stall    [2];
  logic        err      [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;
  logic [31:0] mdl [2][1024];

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .UNCACHED_EXTRA(3)) dut0 (
    .clk(clk), .rst(rst), .memen(memen[0]), .memwrite(memwrite[0]), .paddr(paddr[0]),
    .wdata(wdata[0]), .no_dcache(noDcache[0]), .rdata(rdata[0]), .data_ok(dataOk[0]),
    .stall(stall[0]), .err(err[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .UNCACHED_EXTRA(1)) dut1 (
    .clk(clk), .rst(rst), .memen(memen[1]), .memwrite(memwrite[1]), .paddr(paddr[1]),
    .wdata(wdata[1]), .no_dcache(noDcache[1]), .rdata(rdata[1]), .data_ok(dataOk[1]),
    .stall(stall[1]), .err(err[1])
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one access at posedge+1 in IDLE; returns at posedge+1 after RESP with memen still high.
  task automatic access(input int d, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic nc, output logic [31:0] rd,
                        output logic e, output int lat, output int stc, output int okCyc);
    bit got;
    got = 0; lat = -1; stc = 0; rd = '0; e = 1'b0; okCyc = 0;
    memen[d] = 1'b1; memwrite[d] = we; paddr[d] = addr; wdata[d] = wd; noDcache[d] = nc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dataOk[d]) begin
        got = 1; lat = i; rd = rdata[d]; e = err[d]; okCyc = cyc;
        if (stall[d]) stc = 99;
        break;
      end
      if (stall[d]) stc++;
      @(posedge clk); #1;
      if (i == 0) begin
        memwrite[d] = 4'($urandom); paddr[d] = $urandom; wdata[d] = $urandom;
        noDcache[d] = 1'($urandom);
      end
    end
    if (!got) checkEq($sformatf("d%0d_timeout@%h", d, addr), 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic doCheck(input int d, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic nc, input bit chkRd,
                         output logic [31:0] rd, output int okCyc);
    logic [9:0]  idx;
    logic        bad;
    logic [31:0] expRd;
    int          expLat, lat, stc;
    logic        e;
    idx = addr[11:2];
    bad = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    bad = (addr[31:12] != 20'd0);
`endif
    expRd  = bad ? 32'hDEAD_BEEF : mdl[d][idx];
    expLat = ((d == 0) ? 2 : 0) + (nc ? ((d == 0) ? 3 : 1) : 0) + 1;
    access(d, we, addr, wd, nc, rd, e, lat, stc, okCyc);
    if (chkRd) checkEq($sformatf("d%0d_rdata@%h", d, addr), rd, expRd);
    checkEq($sformatf("d%0d_err@%h", d, addr), 32'(e), 32'(bad));
    checkEq($sformatf("d%0d_latency@%h", d, addr), lat, expLat);
    checkEq($sformatf("d%0d_stallcycles@%h", d, addr), stc, expLat);
    if (!bad) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] rd, old0;
    int c1, c2, seenOk;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      memen[d] = 1'b0; memwrite[d] = 4'h0; paddr[d] = '0; wdata[d] = '0; noDcache[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkEq($sformatf("d%0d_reset_rdata", d), rdata[d], 32'h0);
      checkEq($sformatf("d%0d_reset_dataok", d), 32'(dataOk[d]), 32'h0);
      checkEq($sformatf("d%0d_reset_err", d), 32'(err[d]), 32'h0);
      checkEq($sformatf("d%0d_reset_stall", d), 32'(stall[d]), 32'h0);
    end
    @(posedge clk); #1;

    // Preload the first 64 words of each instance with full-word stores.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) begin
        doCheck(d, 4'hF, 32'(w) << 2, $urandom, 1'($urandom), 0, rd, c1);
      end
      memen[d] = 1'b0;
    end

    // Cached read of 0x100: three stall cycles, data_ok on the fourth.
    doCheck(0, 4'h0, 32'h100, 32'h0, 1'b0, 1, rd, c1);

    // Partial store merges into the existing word; write returns the old word.
    doCheck(0, 4'hF, 32'h104, 32'h1122_3344, 1'b0, 1, rd, c1);
    doCheck(0, 4'b0011, 32'h104, 32'hAABB_CCDD, 1'b0, 1, rd, c1);
    checkEq("t2_prewrite_word", rd, 32'h1122_3344);
    doCheck(0, 4'h0, 32'h104, 32'h0, 1'b0, 1, rd, c1);
    checkEq("t2_merged_word", rd, 32'h1122_CCDD);

    // Uncached read: data_ok six cycles after acceptance.
    doCheck(0, 4'h0, 32'h108, 32'h0, 1'b1, 1, rd, c1);

    // Reset during WAIT of a store: no completion, store dropped.
    memen[0] = 1'b1; memwrite[0] = 4'hF; paddr[0] = 32'h104; wdata[0] = 32'hFFFF_FFFF;
    noDcache[0] = 1'b0;
    @(posedge clk); #1;
    memen[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkEq("t4_stall_after_reset", 32'(stall[0]), 32'h0);
    checkEq("t4_rdata_after_reset", rdata[0], 32'h0);
    seenOk = 0;
    repeat (6) begin
      @(negedge clk);
      if (dataOk[0]) seenOk++;
    end
    checkEq("t4_no_dataok", seenOk, 0);
    @(posedge clk); #1;
    doCheck(0, 4'h0, 32'h104, 32'h0, 1'b0, 1, rd, c1);
    checkEq("t4_word_unchanged", rd, 32'h1122_CCDD);
    memen[0] = 1'b0;

    // Zero-wait back-to-back reads with memen held: data_ok every other cycle.
    doCheck(1, 4'h0, 32'h0, 32'h0, 1'b0, 1, rd, c1);
    doCheck(1, 4'h0, 32'h4, 32'h0, 1'b0, 1, rd, c2);
    checkEq("t5_b2b_gap", c2 - c1, 2);
    memen[1] = 1'b0;

    // Store to 0x1000 aliases word 0 unless the range check rejects it.
    old0 = mdl[0][0];
    doCheck(0, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, 1'b0, 1, rd, c1);
`ifdef DMEM_RANGE_CHECK_EN
    checkEq("t6_bad_rdata", rd, 32'hDEAD_BEEF);
`else
    checkEq("t6_alias_rdata", rd, old0);
`endif
    doCheck(0, 4'h0, 32'h0, 32'h0, 1'b0, 1, rd, c1);
`ifdef DMEM_RANGE_CHECK_EN
    checkEq("t6_word0_kept", rd, old0);
`else
    checkEq("t6_word0_overwritten", rd, 32'hCAFE_F00D);
`endif
    memen[0] = 1'b0;

    // Randomized traffic, with occasional back-to-back requests and idle gaps.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        logic [3:0]  we;
        logic [31:0] addr;
        we   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        addr = {(($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'h0), 4'h0,
                6'($urandom_range(0, 63)), 2'($urandom)};
        doCheck(d, we, addr, $urandom, 1'($urandom), 1, rd, c1);
        if ($urandom_range(0, 2) != 0) begin
          memen[d] = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
      end
      memen[d] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
